// File: rtl/pcie_axi_fence_unit.sv
// Write-fence tracker for the PCIe initiator AXI write path.
// Counts outstanding AWs per ID-selected group and drains a group on fence request.
//
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_s_aw_valid/o_s_aw_ready  upstream AW handshake (ID/payload routed around)
//   i_s_aw_id                  upstream AW ID, selects the fence group
//   o_m_aw_valid/i_m_aw_ready  downstream AW handshake
//   i_b_valid/i_b_ready/i_b_id observed B channel
//   i_fence_req                per-group fence request (level or pulse)
//   o_fence_busy               group draining
//   o_fence_done               one-cycle drain completion pulse
//   o_fence_timeout            sticky drain timeout
//   o_cnt_underflow            sticky B-without-AW error
//   i_err_clear                clears sticky flags
//   o_outstanding              per-group counters, group g at [g*OUTST_W +: OUTST_W]
module pcie_axi_fence_unit #(
    parameter int N_FENCES       = 4,
    parameter int ID_W           = 7,
    parameter int FENCE_SEL_LSB  = 0,
    parameter int OUTST_W        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_s_aw_valid,
    output logic                        o_s_aw_ready,
    input  logic [ID_W-1:0]             i_s_aw_id,
    output logic                        o_m_aw_valid,
    input  logic                        i_m_aw_ready,
    input  logic                        i_b_valid,
    input  logic                        i_b_ready,
    input  logic [ID_W-1:0]             i_b_id,
    input  logic [N_FENCES-1:0]         i_fence_req,
    output logic [N_FENCES-1:0]         o_fence_busy,
    output logic [N_FENCES-1:0]         o_fence_done,
    output logic [N_FENCES-1:0]         o_fence_timeout,
    output logic [N_FENCES-1:0]         o_cnt_underflow,
    input  logic                        i_err_clear,
    output logic [N_FENCES*OUTST_W-1:0] o_outstanding
);

    localparam int SEL_W = $clog2(N_FENCES);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TMR_LAST =
        TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [OUTST_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } fence_state_e;

    fence_state_e                       state_q [N_FENCES];
    fence_state_e                       state_d [N_FENCES];
    logic [N_FENCES-1:0][OUTST_W-1:0]   cnt_q;
    logic [N_FENCES-1:0][OUTST_W-1:0]   cnt_d;
    logic [N_FENCES-1:0][TMR_W-1:0]     tmr_q;
    logic [N_FENCES-1:0][TMR_W-1:0]     tmr_d;
    logic [N_FENCES-1:0]                inc;
    logic [N_FENCES-1:0]                dec;
    logic [N_FENCES-1:0]                done_d;
    logic [N_FENCES-1:0]                done_q;
    logic [N_FENCES-1:0]                tmo_set;
    logic [N_FENCES-1:0]                tmo_q;
    logic [N_FENCES-1:0]                unf_set;
    logic [N_FENCES-1:0]                unf_q;

    logic [SEL_W-1:0] ga;
    logic [SEL_W-1:0] gb;
    logic             blk;
    logic             aw_fire;
    logic             b_fire;
    logic             unused_id;

    assign ga = i_s_aw_id[FENCE_SEL_LSB +: SEL_W];
    assign gb = i_b_id[FENCE_SEL_LSB +: SEL_W];

    // ID bits outside the group slice are carried around the block.
    assign unused_id = ^{i_s_aw_id, i_b_id};

    // A draining group or a saturated counter holds off that group's AWs.
    assign blk = (state_q[ga] == DRAIN) || (cnt_q[ga] == CNT_MAX);

    assign o_m_aw_valid = i_s_aw_valid & ~blk;
    assign o_s_aw_ready = i_m_aw_ready & ~blk;

    assign aw_fire = o_m_aw_valid & i_m_aw_ready;
    assign b_fire  = i_b_valid & i_b_ready;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int g = 0; g < N_FENCES; g++) begin
            inc[g] = aw_fire && (ga == SEL_W'(g));
            dec[g] = b_fire && (gb == SEL_W'(g));
        end
    end

    // Counter update; a B with an empty counter is flagged, count held at 0.
    always_comb begin
        cnt_d   = cnt_q;
        unf_set = '0;
        for (int g = 0; g < N_FENCES; g++) begin
            if (inc[g] && !dec[g]) begin
                cnt_d[g] = cnt_q[g] + 1'b1;
            end else if (dec[g] && !inc[g]) begin
                if (cnt_q[g] == '0) begin
                    unf_set[g] = 1'b1;
                end else begin
                    cnt_d[g] = cnt_q[g] - 1'b1;
                end
            end
        end
    end

    // Per-group fence FSM; drain check looks at the registered count.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        done_d  = '0;
        tmo_set = '0;
        for (int g = 0; g < N_FENCES; g++) begin
            unique case (state_q[g])
                IDLE: begin
                    if (i_fence_req[g]) begin
                        state_d[g] = DRAIN;
                        tmr_d[g]   = '0;
                    end
                end
                DRAIN: begin
                    if (cnt_q[g] == '0) begin
                        state_d[g] = IDLE;
                        done_d[g]  = 1'b1;
                    end else if (TMO_EN) begin
                        if (tmr_q[g] == TMR_LAST) begin
                            tmo_set[g] = 1'b1;
                        end else begin
                            tmr_d[g] = tmr_q[g] + 1'b1;
                        end
                    end
                end
                default: state_d[g] = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= '{default: IDLE};
            cnt_q   <= '0;
            tmr_q   <= '0;
            done_q  <= '0;
            tmo_q   <= '0;
            unf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            // Set has priority over a same-cycle clear.
            tmo_q   <= tmo_set | (tmo_q & ~{N_FENCES{i_err_clear}});
            unf_q   <= unf_set | (unf_q & ~{N_FENCES{i_err_clear}});
        end
    end

    always_comb begin
        o_fence_busy = '0;
        for (int g = 0; g < N_FENCES; g++) begin
            o_fence_busy[g] = (state_q[g] == DRAIN);
        end
    end

    assign o_fence_done    = done_q;
    assign o_fence_timeout = tmo_q;
    assign o_cnt_underflow = unf_q;
    assign o_outstanding   = cnt_q;

endmodule

// File: tb/tb_pcie_axi_fence_unit.sv
// Scoreboard bench for pcie_axi_fence_unit.
// Stimulus queues expected values per cycle; a monitor compares them.
module tb_pcie_axi_fence_unit;

    localparam int N   = 4;
    localparam int IDW = 7;
    localparam int OW  = 8;
    localparam int SOW = 2;
    localparam int TMO = 16;

    localparam int S_OUT   = 0;
    localparam int S_BUSY  = 1;
    localparam int S_TMO   = 2;
    localparam int S_UNF   = 3;
    localparam int S_GATE  = 4;
    localparam int S_SOUT  = 5;
    localparam int S_SGATE = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           aw_valid = 1'b0;
    logic [IDW-1:0] aw_id = '0;
    logic           m_aw_ready = 1'b0;
    logic           b_valid = 1'b0;
    logic           b_ready = 1'b0;
    logic [IDW-1:0] b_id = '0;
    logic [N-1:0]   fence_req = '0;
    logic           err_clear = 1'b0;

    logic           s_aw_ready;
    logic           m_aw_valid;
    logic [N-1:0]   busy;
    logic [N-1:0]   done;
    logic [N-1:0]   tmo;
    logic [N-1:0]   unf;
    logic [N*OW-1:0] outst;

    logic           ss_aw_ready;
    logic           sm_aw_valid;
    logic [N-1:0]   sbusy;
    logic [N-1:0]   sdone;
    logic [N-1:0]   stmo;
    logic [N-1:0]   sunf;
    logic [N*SOW-1:0] soutst;

    always #5 clk = ~clk;

    pcie_axi_fence_unit #(
        .N_FENCES(N), .ID_W(IDW), .FENCE_SEL_LSB(0),
        .OUTST_W(OW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_aw_valid(aw_valid), .o_s_aw_ready(s_aw_ready),
        .i_s_aw_id(aw_id),
        .o_m_aw_valid(m_aw_valid), .i_m_aw_ready(m_aw_ready),
        .i_b_valid(b_valid), .i_b_ready(b_ready), .i_b_id(b_id),
        .i_fence_req(fence_req),
        .o_fence_busy(busy), .o_fence_done(done),
        .o_fence_timeout(tmo), .o_cnt_underflow(unf),
        .i_err_clear(err_clear), .o_outstanding(outst)
    );

    pcie_axi_fence_unit #(
        .N_FENCES(N), .ID_W(IDW), .FENCE_SEL_LSB(0),
        .OUTST_W(SOW), .TIMEOUT_CYCLES(TMO)
    ) dut_s (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_aw_valid(aw_valid), .o_s_aw_ready(ss_aw_ready),
        .i_s_aw_id(aw_id),
        .o_m_aw_valid(sm_aw_valid), .i_m_aw_ready(m_aw_ready),
        .i_b_valid(b_valid), .i_b_ready(b_ready), .i_b_id(b_id),
        .i_fence_req(fence_req),
        .o_fence_busy(sbusy), .o_fence_done(sdone),
        .o_fence_timeout(stmo), .o_cnt_underflow(sunf),
        .i_err_clear(err_clear), .o_outstanding(soutst)
    );

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] val;
        string       nm;
    } exp_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] val;
    } done_t;

    exp_t  exp_q[$];
    done_t done_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] sample(int sig);
        case (sig)
            S_OUT:   return 64'(outst);
            S_BUSY:  return 64'(busy);
            S_TMO:   return 64'(tmo);
            S_UNF:   return 64'(unf);
            S_GATE:  return 64'({m_aw_valid, s_aw_ready});
            S_SOUT:  return 64'(soutst);
            S_SGATE: return 64'({sm_aw_valid, ss_aw_ready});
            default: return '1;
        endcase
    endfunction

    function automatic logic [63:0] ov(int g, int v);
        return 64'(v) << (g * OW);
    endfunction

    function automatic logic [63:0] sov(int g, int v);
        return 64'(v) << (g * SOW);
    endfunction

    always @(negedge clk) begin
        logic [63:0] got;
        done_t       d;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                got = sample(exp_q[i].sig);
                checks++;
                if (got !== exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %0h want %0h",
                             exp_q[i].nm, cyc, got, exp_q[i].val);
                end
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                errors++;
                $display("FAIL %s missed at cyc %0d", exp_q[i].nm, exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
        if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
            errors++;
            $display("FAIL done_missing cyc %0d got 0 want %0h",
                     done_q[0].cyc, done_q[0].val);
            void'(done_q.pop_front());
        end
        if (done !== '0) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc %0d got %0h want 0", cyc, done);
            end else begin
                d = done_q.pop_front();
                if (d.cyc != cyc || d.val !== done) begin
                    errors++;
                    $display("FAIL done_pulse cyc %0d got %0h want %0h at cyc %0d",
                             cyc, done, d.val, d.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(int dly, int sig, logic [63:0] v, string nm);
        exp_q.push_back('{cyc + dly, sig, v, nm});
    endtask

    task automatic dchk(int dly, logic [N-1:0] v);
        done_q.push_back('{cyc + dly, v});
    endtask

    task automatic clr_in();
        aw_valid   = 1'b0;
        aw_id      = '0;
        m_aw_ready = 1'b0;
        b_valid    = 1'b0;
        b_ready    = 1'b0;
        b_id       = '0;
        fence_req  = '0;
        err_clear  = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n      = 1'b0;
        aw_valid   = 1'b1;
        aw_id      = 7'd3;
        m_aw_ready = 1'b1;
        chk(0, S_GATE, 64'b11, "rst_gate_pass");
        chk(0, S_OUT, 0, "rst_outst");
        chk(0, S_BUSY, 0, "rst_busy");
        chk(0, S_TMO, 0, "rst_tmo");
        chk(0, S_UNF, 0, "rst_unf");
        step();
        aw_valid = 1'b0;
        chk(0, S_GATE, 64'b01, "rst_gate_idle");
        step();
        rst_n = 1'b1;
        clr_in();
        step();
    endtask

    initial begin
        step();
        do_reset();

        // Counting on group 1
        m_aw_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            aw_valid = 1'b1;
            aw_id    = 7'd1;
            chk(0, S_GATE, 64'b11, "cnt_aw_pass");
            chk(1, S_OUT, ov(1, i + 1), "cnt_up");
            step();
        end
        aw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_valid = 1'b1;
            b_ready = 1'b1;
            b_id    = 7'd1;
            chk(1, S_OUT, ov(1, 4 - i), "cnt_down");
            step();
        end
        b_valid = 1'b0;
        chk(0, S_UNF, 0, "cnt_no_unf");
        chk(0, S_TMO, 0, "cnt_no_tmo");
        chk(0, S_BUSY, 0, "cnt_no_busy");
        step();

        // Fence drain on group 2
        do_reset();
        m_aw_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            aw_valid = 1'b1;
            aw_id    = 7'd2;
            step();
        end
        aw_valid  = 1'b0;
        fence_req = 4'b0100;
        chk(0, S_OUT, ov(2, 3), "drn_cnt3");
        step();
        fence_req = '0;
        aw_valid  = 1'b1;
        aw_id     = 7'd2;
        chk(0, S_BUSY, 64'b0100, "drn_busy");
        chk(0, S_GATE, 64'b00, "drn_held");
        step();
        aw_id = 7'd0;
        chk(0, S_GATE, 64'b11, "drn_g0_pass");
        step();
        aw_id = 7'd2;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1;
            b_ready = 1'b1;
            b_id    = 7'd2;
            chk(0, S_GATE, 64'b00, "drn_held_b");
            step();
        end
        b_valid = 1'b0;
        chk(0, S_GATE, 64'b00, "drn_held_cnt0");
        chk(0, S_OUT, ov(0, 1), "drn_cnt0");
        dchk(1, 4'b0100);
        chk(1, S_GATE, 64'b11, "drn_release");
        chk(1, S_BUSY, 0, "drn_busy_low");
        step();
        step();
        aw_valid = 1'b0;
        chk(0, S_OUT, ov(0, 1) | ov(2, 1), "drn_4th_acc");
        step();

        // Empty fence on group 3
        do_reset();
        fence_req = 4'b1000;
        chk(1, S_BUSY, 64'b1000, "empty_busy");
        chk(2, S_BUSY, 0, "empty_busy_low");
        dchk(2, 4'b1000);
        step();
        fence_req = '0;
        step();
        step();

        // Simultaneous AW/B, underflow, clear
        do_reset();
        m_aw_ready = 1'b1;
        aw_valid   = 1'b1;
        aw_id      = 7'd0;
        step();
        step();
        b_valid = 1'b1;
        b_ready = 1'b1;
        b_id    = 7'd0;
        chk(0, S_OUT, ov(0, 2), "sim_pre");
        chk(1, S_OUT, ov(0, 2), "sim_same");
        step();
        aw_valid = 1'b0;
        step();
        step();
        chk(0, S_OUT, 0, "sim_drained");
        chk(1, S_UNF, 64'b0001, "unf_set");
        chk(1, S_OUT, 0, "unf_cnt0");
        step();
        b_valid   = 1'b0;
        err_clear = 1'b1;
        chk(1, S_UNF, 0, "unf_clear");
        step();
        b_valid = 1'b1;
        chk(1, S_UNF, 64'b0001, "unf_set_wins");
        step();
        b_valid = 1'b0;
        chk(1, S_UNF, 0, "unf_clear2");
        step();
        err_clear = 1'b0;
        step();

        // Saturation on the narrow-counter instance
        do_reset();
        m_aw_ready = 1'b1;
        aw_valid   = 1'b1;
        aw_id      = 7'd1;
        for (int i = 0; i < 3; i++) begin
            chk(0, S_SGATE, 64'b11, "sat_fill");
            step();
        end
        chk(0, S_SGATE, 64'b00, "sat_block");
        chk(0, S_SOUT, sov(1, 3), "sat_cnt3");
        chk(0, S_GATE, 64'b11, "wide_no_block");
        b_valid = 1'b1;
        b_ready = 1'b1;
        b_id    = 7'd1;
        step();
        b_valid = 1'b0;
        chk(0, S_SGATE, 64'b11, "sat_unblock");
        chk(0, S_SOUT, sov(1, 2), "sat_cnt2");
        step();
        aw_valid = 1'b0;
        chk(0, S_SOUT, sov(1, 3), "sat_refill");
        step();

        // Timeout, sticky flag, reset mid-drain
        do_reset();
        m_aw_ready = 1'b1;
        aw_valid   = 1'b1;
        aw_id      = 7'd0;
        step();
        aw_valid  = 1'b0;
        fence_req = 4'b0001;
        chk(16, S_TMO, 0, "tmo_early");
        chk(17, S_TMO, 64'b0001, "tmo_set");
        chk(17, S_BUSY, 64'b0001, "tmo_busy");
        step();
        fence_req = '0;
        repeat (19) step();
        b_valid = 1'b1;
        b_ready = 1'b1;
        b_id    = 7'd0;
        chk(0, S_BUSY, 64'b0001, "tmo_still_busy");
        step();
        b_valid = 1'b0;
        dchk(1, 4'b0001);
        chk(1, S_BUSY, 0, "tmo_done_idle");
        chk(1, S_TMO, 64'b0001, "tmo_sticky");
        step();
        step();
        err_clear = 1'b1;
        chk(1, S_TMO, 0, "tmo_clear");
        step();
        err_clear = 1'b0;
        aw_valid  = 1'b1;
        aw_id     = 7'd3;
        step();
        aw_valid  = 1'b0;
        fence_req = 4'b1000;
        step();
        fence_req = '0;
        chk(0, S_BUSY, 64'b1000, "mid_busy");
        chk(0, S_OUT, ov(3, 1), "mid_cnt");
        repeat (18) step();
        chk(0, S_TMO, 64'b1000, "mid_tmo");
        step();
        do_reset();
        repeat (4) step();
        chk(0, S_OUT, 0, "post_rst_outst");
        chk(0, S_BUSY, 0, "post_rst_busy");
        repeat (3) step();

        foreach (exp_q[i]) begin
            errors++;
            $display("FAIL %s never compared", exp_q[i].nm);
        end
        foreach (done_q[i]) begin
            errors++;
            $display("FAIL done_never got 0 want %0h", done_q[i].val);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
